// File: rtl/memu_async_pkg.sv
// Shared encodings and width helpers for the split-transaction memory-access stage.
package memu_async_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } mem_size_e;

  localparam int unsigned MEM_OP_RSVD_BIT = 2;
  localparam int unsigned MEM_OP_ZEXT_BIT = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_READY
  } mem_state_e;

  function automatic int unsigned exe2mem_len(input int unsigned dw);
    return dw + 44;
  endfunction

  function automatic int unsigned mem2wb_len(input int unsigned dw);
    return dw + 38;
  endfunction

  function automatic int unsigned memrf_len(input int unsigned dw);
    return dw + 7;
  endfunction

endpackage

// File: rtl/memu_async_if.sv
// EXE->MEM->WB handshake, data SRAM response channel and ID forwarding bundle.
interface memu_async_if #(
  parameter int unsigned DW = 32
);
  import memu_async_pkg::*;

  logic                       mem_allowin;
  logic                       exe_to_mem_valid;
  logic [exe2mem_len(DW)-1:0] exe_to_mem_zip;
  logic                       wb_allowin;
  logic                       mem_flush;
  logic                       mem_to_wb_valid;
  logic [mem2wb_len(DW)-1:0]  mem_to_wb_zip;
  logic                       data_sram_data_ok;
  logic [DW-1:0]              data_sram_rdata;
  logic [memrf_len(DW)-1:0]   mem_rf_zip;

  modport master (
    output exe_to_mem_valid, exe_to_mem_zip, wb_allowin, mem_flush,
           data_sram_data_ok, data_sram_rdata,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_zip, mem_rf_zip
  );

  modport slave (
    input  exe_to_mem_valid, exe_to_mem_zip, wb_allowin, mem_flush,
           data_sram_data_ok, data_sram_rdata,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_zip, mem_rf_zip
  );

endinterface

// File: rtl/load_align.sv
// Combinational load lane select and sign/zero extension for a DW-bit data word.
module load_align
  import memu_async_pkg::*;
#(
  parameter int unsigned DW = 32,
  localparam int unsigned OW = $clog2(DW / 8)
) (
  input  logic [DW-1:0] rdata,
  input  logic [OW-1:0] offset,
  input  logic [3:0]    mem_op,
  output logic [DW-1:0] ext_data
);

  mem_size_e             size;
  int unsigned           nbits;
  logic [OW-1:0]         lane;
  logic [DW-1:0]         shifted;
  logic [DW-1:0]         mask;
  logic [DW-1:0]         val;
  logic [$clog2(DW)-1:0] msb;

  always_comb begin
    size    = mem_size_e'(mem_op[1:0]);
    // offset bits finer than the access size are dropped so the lane is naturally aligned
    lane    = offset & ~OW'((32'd1 << mem_op[1:0]) - 32'd1);
    shifted = rdata >> {lane, 3'b000};
    nbits   = 32'd8 << mem_op[1:0];
    mask    = {DW{1'b1}} >> (DW - nbits);
    val     = shifted & mask;
    msb     = $clog2(DW)'(nbits - 32'd1);
    ext_data = (!mem_op[MEM_OP_ZEXT_BIT] && shifted[msb]) ? (val | ~mask) : val;
    if (mem_op[MEM_OP_RSVD_BIT] || (size == SZ_DOUBLE && DW != 64)) begin
      ext_data = '0;
    end
  end

endmodule

// File: rtl/memu_async.sv
// MEM stage for a split-transaction data SRAM: waits for data_ok, buffers load
// data while WB stalls, and discards responses owed to flushed loads.
module memu_async
  import memu_async_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned CANCEL_W = 2
) (
  input logic        clk,
  input logic        resetn,
  memu_async_if.slave bus
);

  localparam int unsigned OW = $clog2(DW / 8);
  localparam int unsigned ZW = exe2mem_len(DW);

  mem_state_e          state, state_nxt;
  logic [CANCEL_W-1:0] cancel_cnt, cancel_nxt;
  logic [DW-1:0]       rdata_buf;
  logic [ZW-2:0]       zip_r;

  logic          res_from_mem, rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] alu_result;
  logic [3:0]    mem_op;
  logic [31:0]   pc;

  assign res_from_mem = zip_r[DW+42];
  assign rf_we        = zip_r[DW+41];
  assign rf_waddr     = zip_r[DW+40:DW+36];
  assign alu_result   = zip_r[DW+35:36];
  assign mem_op       = zip_r[35:32];
  assign pc           = zip_r[31:0];

  logic          mem_valid, data_ok_eff, ready_go, leave, entry;
  logic          to_hold, cancel_inc, cancel_dec, fwd_stall;
  logic [DW-1:0] load_src, load_ext, rf_wdata;

  assign mem_valid   = (state != S_IDLE);
  assign data_ok_eff = bus.data_sram_data_ok && (cancel_cnt == '0);
  assign ready_go    = (state == S_READY) || (state == S_HOLD) ||
                       ((state == S_WAIT) && data_ok_eff);

  assign bus.mem_allowin     = !bus.mem_flush &&
                               ((state == S_IDLE) || (ready_go && bus.wb_allowin));
  assign bus.mem_to_wb_valid = mem_valid && ready_go;

  assign leave   = bus.mem_to_wb_valid && bus.wb_allowin;
  assign entry   = bus.exe_to_mem_valid && bus.mem_allowin;
  assign to_hold = (state == S_WAIT) && data_ok_eff && !bus.wb_allowin && !bus.mem_flush;

  always_comb begin
    state_nxt = state;
    if (bus.mem_flush) begin
      state_nxt = S_IDLE;
    end else begin
      if (to_hold) state_nxt = S_HOLD;
      if (leave)   state_nxt = S_IDLE;
      if (entry)   state_nxt = bus.exe_to_mem_zip[ZW-1] ? S_WAIT : S_READY;
    end
  end

  // A killed WAIT still owes one response; a drop and a new debt in one cycle cancel out.
  assign cancel_inc = bus.mem_flush && (state == S_WAIT) && !data_ok_eff;
  assign cancel_dec = bus.data_sram_data_ok && (cancel_cnt != '0);

  always_comb begin
    cancel_nxt = cancel_cnt;
    if (cancel_inc && !cancel_dec) begin
      if (cancel_cnt != '1) cancel_nxt = cancel_cnt + 1'b1;
    end else if (cancel_dec && !cancel_inc) begin
      cancel_nxt = cancel_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cancel_cnt <= '0;
      rdata_buf  <= '0;
      zip_r      <= '0;
    end else begin
      state      <= state_nxt;
      cancel_cnt <= cancel_nxt;
      if (to_hold) rdata_buf <= bus.data_sram_rdata;
      if (entry)   zip_r     <= bus.exe_to_mem_zip[ZW-2:0];
    end
  end

  assign load_src = (state == S_HOLD) ? rdata_buf : bus.data_sram_rdata;

  load_align #(.DW(DW)) u_load_align (
    .rdata    (load_src),
    .offset   (alu_result[OW-1:0]),
    .mem_op   (mem_op),
    .ext_data (load_ext)
  );

  assign rf_wdata  = res_from_mem ? load_ext : alu_result;
  assign fwd_stall = (state == S_WAIT) && res_from_mem && !data_ok_eff;

  assign bus.mem_to_wb_zip = {rf_we, rf_waddr, rf_wdata, pc};
  assign bus.mem_rf_zip    = {mem_valid && rf_we, fwd_stall, rf_waddr, rf_wdata};

  a_no_stray_data_ok: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.data_sram_data_ok && (cancel_cnt == '0) &&
      ((state == S_IDLE) || (state == S_READY))));

  a_cancel_no_saturate: assert property (@(posedge clk) disable iff (!resetn)
    !(cancel_inc && !cancel_dec && (cancel_cnt == '1)));

endmodule

// File: tb/tb_memu_async.sv
// Self-checking bench for memu_async: directed tables, corner sequences, randomized model run.
`timescale 1ns/1ps
module tb_memu_async;
  import memu_async_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  memu_async_if #(.DW(32)) b32 ();
  memu_async_if #(.DW(64)) b64 ();

  memu_async #(.DW(32), .CANCEL_W(2)) u32 (.clk(clk), .resetn(resetn), .bus(b32));
  memu_async #(.DW(64), .CANCEL_W(2)) u64 (.clk(clk), .resetn(resetn), .bus(b64));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_all();
    b32.exe_to_mem_valid = 1'b0; b32.exe_to_mem_zip = '0; b32.wb_allowin = 1'b1;
    b32.mem_flush = 1'b0; b32.data_sram_data_ok = 1'b0; b32.data_sram_rdata = '0;
    b64.exe_to_mem_valid = 1'b0; b64.exe_to_mem_zip = '0; b64.wb_allowin = 1'b1;
    b64.mem_flush = 1'b0; b64.data_sram_data_ok = 1'b0; b64.data_sram_rdata = '0;
  endtask

  function automatic logic [75:0] zip32(input bit req, input bit res, input bit we,
      input logic [4:0] wa, input logic [31:0] alu, input logic [3:0] op, input logic [31:0] pc);
    return {req, res, we, wa, alu, op, pc};
  endfunction

  function automatic logic [107:0] zip64(input bit req, input bit res, input bit we,
      input logic [4:0] wa, input logic [63:0] alu, input logic [3:0] op, input logic [31:0] pc);
    return {req, res, we, wa, alu, op, pc};
  endfunction

  // Reference load extraction: pick the aligned lane by byte arithmetic, then extend.
  function automatic logic [31:0] ref_load32(input logic [31:0] d, input logic [1:0] off,
                                             input logic [3:0] op);
    int unsigned nbytes, base;
    logic [63:0] v, m;
    if (op[2] || op[1:0] == 2'd3) return 32'h0;
    nbytes = 1 << op[1:0];
    base   = (off / nbytes) * nbytes;
    v      = {32'h0, d} >> (8 * base);
    m      = (64'd1 << (8 * nbytes)) - 64'd1;
    v      = v & m;
    if (!op[3] && v[8*nbytes-1]) v = v | ~m;
    return v[31:0];
  endfunction

  typedef struct {
    bit          w64;
    logic [3:0]  op;
    logic [2:0]  off;
    logic [63:0] rdata;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[$];

  // random-run model of the single MEM slot
  bit          m_occ, m_got, m_req, m_res, m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_alu, m_pc, m_buf;
  logic [3:0]  m_op;
  int          m_cancel;

  initial begin
    resetn = 1'b0;
    idle_all();

    vt.push_back('{1'b0, 4'd0,  3'd3, 64'h80FF_0000, 64'hFFFF_FF80});
    vt.push_back('{1'b0, 4'd8,  3'd3, 64'h80FF_0000, 64'h0000_0080});
    vt.push_back('{1'b0, 4'd9,  3'd2, 64'h80FF_0000, 64'h0000_80FF});
    vt.push_back('{1'b0, 4'd1,  3'd3, 64'h80FF_0000, 64'hFFFF_80FF});
    vt.push_back('{1'b0, 4'd2,  3'd1, 64'h80FF_0000, 64'h80FF_0000});
    vt.push_back('{1'b0, 4'd8,  3'd0, 64'h1234_5678, 64'h0000_0078});
    vt.push_back('{1'b0, 4'd0,  3'd1, 64'h1234_5678, 64'h0000_0056});
    vt.push_back('{1'b0, 4'd1,  3'd0, 64'h1234_F678, 64'hFFFF_F678});
    vt.push_back('{1'b0, 4'd4,  3'd1, 64'h80FF_0000, 64'h0});
    vt.push_back('{1'b0, 4'd3,  3'd0, 64'h80FF_0000, 64'h0});
    vt.push_back('{1'b0, 4'd12, 3'd0, 64'hFFFF_FFFF, 64'h0});
    vt.push_back('{1'b1, 4'd10, 3'd4, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_DEAD_BEEF});
    vt.push_back('{1'b1, 4'd2,  3'd4, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_DEAD_BEEF});
    vt.push_back('{1'b1, 4'd3,  3'd5, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001});
    vt.push_back('{1'b1, 4'd0,  3'd7, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFDE});
    vt.push_back('{1'b1, 4'd9,  3'd7, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_DEAD});
    vt.push_back('{1'b1, 4'd1,  3'd4, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_BEEF});
    vt.push_back('{1'b1, 4'd8,  3'd0, 64'hDEAD_BEEF_0000_0001, 64'h1});
    vt.push_back('{1'b1, 4'd2,  3'd1, 64'hDEAD_BEEF_0000_0001, 64'h1});

    // reset state
    step(); step(); settle();
    check("rst_valid",   b32.mem_to_wb_valid, 0);
    check("rst_allowin", b32.mem_allowin,     1);
    check("rst_fwd_we",  b32.mem_rf_zip[38],  0);
    check("rst_stall",   b32.mem_rf_zip[37],  0);
    check("rst_valid64", b64.mem_to_wb_valid, 0);
    resetn = 1'b1;
    step();

    // load-align tables, data_ok in the first MEM cycle
    foreach (vt[k]) begin
      if (!vt[k].w64) begin
        b32.exe_to_mem_valid = 1'b1;
        b32.exe_to_mem_zip = zip32(1, 1, 1, 5'd9, {30'h400, vt[k].off[1:0]}, vt[k].op, 32'h80);
        step();
        b32.exe_to_mem_valid = 1'b0;
        b32.data_sram_data_ok = 1'b1;
        b32.data_sram_rdata = vt[k].rdata[31:0];
        settle();
        check($sformatf("vec%0d_valid", k), b32.mem_to_wb_valid, 1);
        check($sformatf("vec%0d_data", k), b32.mem_to_wb_zip[63:32], vt[k].exp[31:0]);
        step();
        b32.data_sram_data_ok = 1'b0;
      end else begin
        b64.exe_to_mem_valid = 1'b1;
        b64.exe_to_mem_zip = zip64(1, 1, 1, 5'd9, {61'h200, vt[k].off}, vt[k].op, 32'h80);
        step();
        b64.exe_to_mem_valid = 1'b0;
        b64.data_sram_data_ok = 1'b1;
        b64.data_sram_rdata = vt[k].rdata;
        settle();
        check($sformatf("vec%0d_valid", k), b64.mem_to_wb_valid, 1);
        check($sformatf("vec%0d_data", k), b64.mem_to_wb_zip[95:32], vt[k].exp);
        step();
        b64.data_sram_data_ok = 1'b0;
      end
    end

    // ld.b with late data_ok: stall visible to ID for three cycles
    b32.exe_to_mem_valid = 1'b1;
    b32.exe_to_mem_zip = zip32(1, 1, 1, 5'd7, 32'h1000_0003, 4'd0, 32'h100);
    step();
    b32.exe_to_mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("ldb_stall", b32.mem_rf_zip[37], 1);
      check("ldb_wait_valid", b32.mem_to_wb_valid, 0);
      step();
    end
    b32.data_sram_data_ok = 1'b1;
    b32.data_sram_rdata = 32'h80FF_0000;
    settle();
    check("ldb_stall_off", b32.mem_rf_zip[37], 0);
    check("ldb_valid", b32.mem_to_wb_valid, 1);
    check("ldb_data", b32.mem_to_wb_zip[63:32], 32'hFFFF_FF80);
    step();
    b32.data_sram_data_ok = 1'b0;
    settle();
    check("ldb_gone", b32.mem_to_wb_valid, 0);

    // ld.hu captured into the hold buffer while WB stalls
    b32.exe_to_mem_valid = 1'b1;
    b32.exe_to_mem_zip = zip32(1, 1, 1, 5'd3, 32'h2000_0002, 4'd9, 32'h104);
    step();
    b32.exe_to_mem_valid = 1'b0;
    b32.data_sram_data_ok = 1'b1;
    b32.data_sram_rdata = 32'h80FF_0000;
    b32.wb_allowin = 1'b0;
    settle();
    check("hold_valid", b32.mem_to_wb_valid, 1);
    check("hold_allowin", b32.mem_allowin, 0);
    step();
    b32.data_sram_data_ok = 1'b0;
    b32.data_sram_rdata = 32'hDEAD_DEAD;
    settle();
    check("hold_data1", b32.mem_to_wb_zip[63:32], 32'h0000_80FF);
    step();
    b32.wb_allowin = 1'b1;
    settle();
    check("hold_out_valid", b32.mem_to_wb_valid, 1);
    check("hold_out_data", b32.mem_to_wb_zip[63:32], 32'h0000_80FF);
    check("hold_out_allowin", b32.mem_allowin, 1);
    step();
    settle();
    check("hold_gone", b32.mem_to_wb_valid, 0);

    // flush in WAIT: the stale beat is dropped, the next one belongs to the new load
    b32.exe_to_mem_valid = 1'b1;
    b32.exe_to_mem_zip = zip32(1, 1, 1, 5'd1, 32'h3000_0000, 4'd2, 32'h108);
    step();
    b32.exe_to_mem_valid = 1'b0;
    b32.mem_flush = 1'b1;
    settle();
    check("flush_allowin", b32.mem_allowin, 0);
    step();
    b32.mem_flush = 1'b0;
    b32.exe_to_mem_valid = 1'b1;
    b32.exe_to_mem_zip = zip32(1, 1, 1, 5'd2, 32'h3000_0004, 4'd2, 32'h10C);
    settle();
    check("flush_reentry_allowin", b32.mem_allowin, 1);
    step();
    b32.exe_to_mem_valid = 1'b0;
    b32.data_sram_data_ok = 1'b1;
    b32.data_sram_rdata = 32'h1111_1111;
    settle();
    check("drop_valid", b32.mem_to_wb_valid, 0);
    check("drop_stall", b32.mem_rf_zip[37], 1);
    step();
    b32.data_sram_rdata = 32'h2222_2222;
    settle();
    check("second_valid", b32.mem_to_wb_valid, 1);
    check("second_data", b32.mem_to_wb_zip[63:32], 32'h2222_2222);
    check("second_pc", b32.mem_to_wb_zip[31:0], 32'h10C);
    step();
    b32.data_sram_data_ok = 1'b0;

    // reset while in WAIT with one response owed
    b32.exe_to_mem_valid = 1'b1;
    b32.exe_to_mem_zip = zip32(1, 1, 1, 5'd4, 32'h4000_0000, 4'd2, 32'h110);
    step();
    b32.exe_to_mem_valid = 1'b0;
    b32.mem_flush = 1'b1;
    step();
    b32.mem_flush = 1'b0;
    b32.exe_to_mem_valid = 1'b1;
    step();
    b32.exe_to_mem_valid = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    settle();
    check("rst2_valid", b32.mem_to_wb_valid, 0);
    check("rst2_allowin", b32.mem_allowin, 1);
    check("rst2_stall", b32.mem_rf_zip[37], 0);
    b32.exe_to_mem_valid = 1'b1;
    b32.exe_to_mem_zip = zip32(1, 1, 1, 5'd4, 32'h4000_0000, 4'd2, 32'h114);
    step();
    b32.exe_to_mem_valid = 1'b0;
    b32.data_sram_data_ok = 1'b1;
    b32.data_sram_rdata = 32'h55AA_55AA;
    settle();
    check("rst2_cancel_clear", b32.mem_to_wb_valid, 1);
    check("rst2_data", b32.mem_to_wb_zip[63:32], 32'h55AA_55AA);
    step();
    b32.data_sram_data_ok = 1'b0;

    // back-to-back ALU instructions at full rate
    for (int i = 0; i < 6; i++) begin
      b32.exe_to_mem_valid = 1'b1;
      b32.exe_to_mem_zip = zip32(0, 0, 1, 5'(i), 32'hA000_0000 + 32'(i), 4'd2, 32'h200 + 32'(4 * i));
      settle();
      check("b2b_allowin", b32.mem_allowin, 1);
      if (i > 0) begin
        check("b2b_valid", b32.mem_to_wb_valid, 1);
        check("b2b_data", b32.mem_to_wb_zip[63:32], 32'hA000_0000 + 32'(i - 1));
        check("b2b_pc", b32.mem_to_wb_zip[31:0], 32'h200 + 32'(4 * (i - 1)));
      end
      step();
    end
    b32.exe_to_mem_valid = 1'b0;
    settle();
    check("b2b_last", b32.mem_to_wb_zip[63:32], 32'hA000_0005);
    step();

    // randomized run against the slot model
    idle_all();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    m_occ = 0; m_got = 0; m_cancel = 0;
    m_req = 0; m_res = 0; m_we = 0; m_wa = '0; m_alu = '0; m_pc = '0; m_op = '0; m_buf = '0;
    for (int c = 0; c < 3000; c++) begin
      bit ev, wa, dok, fl, eff, ready, allow, vld, stall, inc;
      bit n_req, n_res, n_we;
      logic [4:0]  n_wa;
      logic [31:0] n_alu, n_pc, rd, wdata;
      logic [3:0]  n_op;
      ev    = ($urandom_range(0, 3) != 0);
      n_req = $urandom_range(0, 1) != 0;
      n_res = n_req && ($urandom_range(0, 3) != 0);
      n_we  = $urandom_range(0, 1) != 0;
      n_wa  = 5'($urandom);
      n_alu = $urandom;
      n_pc  = $urandom;
      n_op  = 4'($urandom);
      wa    = ($urandom_range(0, 3) != 0);
      rd    = $urandom;
      dok   = ((m_cancel > 0) || (m_occ && m_req && !m_got)) && ($urandom_range(0, 2) != 0);
      eff   = dok && (m_cancel == 0);
      fl    = ($urandom_range(0, 15) == 0);
      if (fl && m_occ && m_req && !m_got && !eff && !(dok && m_cancel > 0) && m_cancel == 3)
        fl = 1'b0;
      inc   = fl && m_occ && m_req && !m_got && !eff;
      ready = m_occ && (!m_req || m_got || eff);
      allow = !fl && (!m_occ || (ready && wa));
      vld   = m_occ && ready;
      wdata = m_res ? ref_load32(m_got ? m_buf : rd, m_alu[1:0], m_op) : m_alu;
      stall = m_occ && m_req && !m_got && m_res && !eff;

      b32.exe_to_mem_valid  = ev;
      b32.exe_to_mem_zip    = zip32(n_req, n_res, n_we, n_wa, n_alu, n_op, n_pc);
      b32.wb_allowin        = wa;
      b32.mem_flush         = fl;
      b32.data_sram_data_ok = dok;
      b32.data_sram_rdata   = rd;
      settle();
      check("rnd_allowin", b32.mem_allowin, allow);
      check("rnd_valid", b32.mem_to_wb_valid, vld);
      check("rnd_fwd_we", b32.mem_rf_zip[38], m_occ && m_we);
      check("rnd_stall", b32.mem_rf_zip[37], stall);
      if (vld) check("rnd_wb_zip", b32.mem_to_wb_zip, {m_we, m_wa, wdata, m_pc});
      if (m_occ) check("rnd_rf_zip", b32.mem_rf_zip[36:0], {m_wa, wdata});

      if (dok && m_cancel > 0) m_cancel--;
      if (inc) m_cancel++;
      if (!fl && m_occ && m_req && !m_got && eff && !wa) begin
        m_got = 1;
        m_buf = rd;
      end
      if (fl) begin
        m_occ = 0;
      end else begin
        if (vld && wa) m_occ = 0;
        if (ev && allow) begin
          m_occ = 1; m_got = 0;
          m_req = n_req; m_res = n_res; m_we = n_we; m_wa = n_wa;
          m_alu = n_alu; m_op = n_op; m_pc = n_pc;
        end
      end
      step();
    end

    idle_all();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memu_async.md
# memu_async

Parametrised memory-access pipeline stage, the successor to the fixed-latency MEM stage. It sits between EXE and WB. It handles a split-transaction data SRAM, where EXE issues the request and this stage waits for `data_sram_data_ok`. Load data is buffered when WB stalls, and an in-flight load response is discarded after a flush. Load alignment and extension are generalised to 32- or 64-bit datapaths.

## Interface
Parameters:
- `DW`, default 32: datapath width, 32 or 64. It sets the widths of `alu_result`, `rdata` and `wdata`.
- `CANCEL_W`, default 2: width of the counter of outstanding responses to discard.

Ports:
- `clk` input 1: the single clock.
- `resetn` input 1: reset, synchronous and active-low.
- `mem_allowin` output 1: MEM can accept an instruction from EXE this cycle.
- `exe_to_mem_valid` input 1: EXE is presenting a valid instruction.
- `exe_to_mem_zip` input DW+44: `{req, res_from_mem, rf_we, rf_waddr[4:0], alu_result[DW-1:0], mem_op[3:0], pc[31:0]}`. `req`=1 means EXE issued an SRAM request that was accepted (`addr_ok` seen).
- `wb_allowin` input 1: WB can accept an instruction this cycle.
- `mem_flush` input 1: kill the instruction currently in MEM.
- `mem_to_wb_valid` output 1: MEM is presenting a valid instruction to WB.
- `mem_to_wb_zip` output DW+38: `{rf_we, rf_waddr, rf_wdata[DW-1:0], pc}`.
- `data_sram_data_ok` input 1: a response beat is present this cycle. Responses return in request order.
- `data_sram_rdata` input DW: response data, valid only when `data_ok`=1.
- `mem_rf_zip` output DW+7: `{fwd_we, fwd_stall, rf_waddr, rf_wdata}`, the forwarding bundle to ID.

## Operation
- `mem_op` encoding:
  - `[1:0]` is size: 0 = byte, 1 = half, 2 = word, 3 = double. Double is legal only when `DW`=64; otherwise the result is 0.
  - `[3]` = 1 means zero-extend, otherwise sign-extend.
  - Any other code yields 0.
- Lane selection:
  - Byte offset is `alu_result[log2(DW/8)-1:0]`.
  - The selected lane is aligned to its size; low offset bits below the size granularity are ignored.
  - The lane is extended to DW bits.
- `rf_wdata` = `res_from_mem` ? extended load data : `alu_result`.
- FSM states:
  - IDLE: no valid instruction in MEM.
  - WAIT: valid instruction with `req`=1 and no data yet.
  - HOLD: data captured in `rdata_buf` while the instruction is not yet passed to WB.
  - READY: valid instruction that needs no data.
- Transitions:
  - On entry (`exe_to_mem_valid & mem_allowin`): WAIT if `req` is set, else READY.
  - WAIT with effective `data_ok` and `wb_allowin`: the instruction leaves this cycle.
  - WAIT with effective `data_ok` and no `wb_allowin`: go to HOLD.
  - HOLD or READY with `wb_allowin`: the instruction leaves.
  - Whenever the instruction leaves, go to IDLE, or to the new entry's state if one is accepted in the same cycle.
- Effective `data_ok` = `data_sram_data_ok & (cancel_cnt==0)`.
- `mem_ready_go` = (READY | HOLD | (WAIT & effective `data_ok`)).
- `mem_allowin` = IDLE | (`mem_ready_go` & `wb_allowin`).
- `mem_to_wb_valid` = `mem_valid` & `mem_ready_go`.
- In WAIT, data is taken directly from `data_sram_rdata`. In HOLD, it comes from `rdata_buf`.
- Flush:
  - `mem_flush` moves the FSM to IDLE.
  - If the flush hits WAIT and no effective `data_ok` arrives in that cycle, `cancel_cnt` increments.
  - Each `data_sram_data_ok` seen while `cancel_cnt`>0 decrements it and is dropped.
  - `cancel_cnt` saturates at its maximum value. Saturation is a protocol error that must never occur under legal stimulus.
  - Flush has priority over a simultaneous entry: `mem_allowin` is forced to 0 during `mem_flush`.
- Forwarding:
  - `fwd_we` = `mem_valid & rf_we`.
  - `fwd_stall` = WAIT & `res_from_mem` & no effective `data_ok`. It tells ID the load value is not yet available.

## Timing
- Reset (`resetn`=0 at a clk edge):
  - State is IDLE, `cancel_cnt`=0, and `rdata_buf` is cleared.
  - Outputs: `mem_to_wb_valid`=0, `mem_allowin`=1, `fwd_we`=0, `fwd_stall`=0.
  - Zip data fields are don't-care but driven deterministically from the registers.
- Non-memory instructions pass through with 1-cycle latency, the same as the old stage.
- Loads and stores with `req`: the earliest `data_ok` is the first cycle in MEM, which is combinational pass-through. There is no upper bound; the stage stalls in WAIT.
- `data_ok` arriving in IDLE or READY with `cancel_cnt`=0 is illegal (assertion).
- A simultaneous leave and entry is supported, giving full throughput with 1-cycle SRAM responses.
- The `rdata_buf` write happens only on the WAIT→HOLD transition.

## Structure
- The shared package or `macros.h` gets:
  - the `mem_op` size and sign encodings,
  - the `EXE2MEM_LEN` and `MEM2WB_LEN` expressions in terms of DW,
  - the FSM state constants.
- One sub-module, `load_align`, is purely combinational and parametrised by DW. It takes `rdata`, offset and `mem_op`, and produces the extended data. It is reusable for a future cache refill path.

## Test plan
- Reset in the middle of WAIT with `cancel_cnt`=1 → next cycle IDLE, `cancel_cnt`=0, `mem_to_wb_valid`=0, `mem_allowin`=1.
- DW=32, `ld.b` (`mem_op`=0) at offset 3, `rdata`=0x80FF_0000, `data_ok` 3 cycles after entry → `fwd_stall`=1 for 3 cycles, then WB receives 0xFFFF_FF80.
- `ld.hu` (`mem_op`=9) at offset 2, `data_ok` while `wb_allowin`=0 for 2 cycles → HOLD, then WB receives 0x0000_80FF after `wb_allowin` rises.
- Flush in WAIT, next load enters, two `data_ok` beats with 0x1111_1111 then 0x2222_2222 → first beat dropped, second beat forwarded to WB.
- DW=64, `ld.wu` (`mem_op`=10) at offset 4, `rdata`=0xDEAD_BEEF_0000_0001 → 0x0000_0000_DEAD_BEEF.
- Back-to-back ALU instructions with `wb_allowin`=1 → one retirement per cycle, `mem_allowin` held at 1.
